uart_tx_flex: RTL and testbench
===============================

Name: uart_tx_flex

Overview:
Parametrised UART transmitter; the next generation of the team's fixed 8-bit UART TX. It adds configurable data width up to DATA_WIDTH, a parametrised divider width, MSB/LSB-first order, CTS flow control, break generation and a frame-done pulse. It sits between the UART register/FIFO layer (valid/ready source) and the pad. tx_o is fully registered.

Parameters:
DATA_WIDTH, 9, maximum data bits per frame; legal range 5..16.
DIV_WIDTH, 16, width of the baud divider and counter.

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
cfg_en_i  in  1  block enable; low aborts any frame immediately
cfg_div_i  in  DIV_WIDTH  bit period = cfg_div_i+1 clk cycles
cfg_bits_i  in  4  data bits minus 1; legal 4..DATA_WIDTH-1
cfg_parity_en_i  in  1  parity bit enable
cfg_parity_sel_i  in  2  00 even, 01 odd, 10 space(0), 11 mark(1)
cfg_stop_bits_i  in  1  0 one stop bit, 1 two stop bits
cfg_msb_first_i  in  1  1 = shift MSB of the configured width first
cfg_cts_en_i  in  1  enable CTS gating
cfg_break_i  in  1  request line break (tx_o held low)
cts_n_i  in  1  asynchronous clear-to-send, active low
tx_data_i  in  DATA_WIDTH  frame data; bits at or above the configured width are ignored
tx_valid_i  in  1  data valid
tx_ready_o  out  1  accept strobe
tx_o  out  1  serial line, registered
busy_o  out  1  frame in progress
done_o  out  1  one-cycle pulse at the end of a frame

Behaviour:
- Reset: tx_o=1, busy_o=0, done_o=0, tx_ready_o=0, state IDLE, all counters 0, CTS synchroniser flops 1.
- Configured width: N = cfg_bits_i+1. If cfg_bits_i < 4 or cfg_bits_i > DATA_WIDTH-1, N = DATA_WIDTH.
- CTS: cts_n_i passes through a 2-flop synchroniser to give cts_s.
- Ready: tx_ready_o = cfg_en_i & (state==IDLE) & ~cfg_break_i & ~(cfg_cts_en_i & cts_s). It is combinational from state and inputs.
- Handshake: transfer occurs when tx_valid_i & tx_ready_o. At that edge the data is latched, masked to N bits, and bit-reversed within N when cfg_msb_first_i=1. tx_o becomes 0 (start bit) and busy_o becomes 1 on the same edge.
- Config sampling: cfg_* other than cfg_en_i are sampled on every cycle. Software changes them only while busy_o=0.
- States: IDLE, BREAK, START, DATA, PARITY, STOP1, STOP2.
- Bit timing: the baud counter runs 0..cfg_div_i and restarts on each state entry. Every bit, including start, parity and stop, lasts exactly cfg_div_i+1 cycles. cfg_div_i=0 gives one cycle per bit.
- Transitions:
  - IDLE -> START on handshake.
  - START -> DATA.
  - DATA shifts one bit per bit period for N bits, then -> PARITY if cfg_parity_en_i, else -> STOP1.
  - PARITY -> STOP1.
  - STOP1 -> STOP2 if cfg_stop_bits_i, else -> IDLE.
  - STOP2 -> IDLE.
- Parity: XOR of the N transmitted data bits. Even mode outputs that XOR; odd mode outputs its inverse.
- Frame length: (1+N+P+S)*(cfg_div_i+1) cycles, where P = parity enabled (0/1) and S = number of stop bits (1/2).
- Frame end: busy_o falls and done_o pulses high for 1 cycle on the edge leaving the last stop bit.
  - A new handshake is allowed in that same IDLE cycle.
  - Its start bit therefore follows the stop bit with no idle gap.
- Break:
  - cfg_break_i=1 in IDLE -> BREAK on the next edge; tx_o=0, busy_o=1.
  - A break requested mid-frame waits until the frame ends; the frame is never corrupted.
  - BREAK -> IDLE on the edge after cfg_break_i falls; tx_o=1 on that edge.
  - done_o is not pulsed for a break.
- CTS deassertion mid-frame does not abort; it only blocks the next handshake.
- cfg_en_i low:
  - Next edge forces IDLE, tx_o=1, busy_o=0, counters 0.
  - No done_o pulse; the data in flight is dropped.
  - tx_ready_o is 0 while cfg_en_i is low.
- Simultaneous: cfg_en_i=0 has priority over everything. Break has priority over a new handshake in IDLE.

Test Plan:
- div=3, N=8, no parity, 1 stop, send 0xA5 LSB-first.
  -> tx_o = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; 40 cycles total; done_o pulses once; busy_o high for 40 cycles.
- div=0, N=9 (cfg_bits_i=8), odd parity, 2 stops, data 0x1FF, MSB-first.
  -> start, nine 1s, parity 0, two stop bits 1; 13 cycles total.
- Back-to-back: tx_valid_i held high with 0x55 then 0x0F, N=5, div=1.
  -> second start bit immediately follows the first stop bit; the second frame sends the low 5 bits 01111 LSB-first as 1,1,1,1,0.
- CTS: cfg_cts_en_i=1, cts_n_i=1.
  -> tx_ready_o stays 0.
  -> After cts_n_i drops, tx_ready_o rises 2 cycles later.
  -> Raising cts_n_i mid-frame lets the frame complete.
- Break asserted at the 3rd data bit of a frame.
  -> Frame completes unchanged, then tx_o=0 and busy_o=1 until cfg_break_i falls; no done_o pulse.
- cfg_en_i dropped during DATA.
  -> Next cycle tx_o=1, busy_o=0, no done_o.
  -> After re-enable, the next frame transmits correctly.
- Async reset mid-frame.
  -> Outputs return to their reset values immediately.

Source files
------------

// File: rtl/uart_tx_flex_if.sv
// rtl/uart_tx_flex_if.sv - valid/ready data channel into the UART transmitter
//
// Purpose: carries one frame's data word from the register/FIFO layer into the
// transmitter.
// Signals:
//   tx_data   frame data, DATA_WIDTH bits (bits above the configured width ignored)
//   tx_valid  source has a word
//   tx_ready  transmitter accepts the word this cycle
// Modports: master = data source, slave = transmitter.

interface uart_tx_flex_if #(
  parameter int DATA_WIDTH = 9
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_flex.sv
// rtl/uart_tx_flex.sv - parametrised UART transmitter with CTS and break
//
// Purpose: serialises words from a valid/ready source onto a registered UART
// line: start bit, 5..DATA_WIDTH data bits (LSB or MSB first), optional
// parity, one or two stop bits. Adds CTS gating and line break generation.
// Ports:
//   clk_i, rst_n_i     clock, asynchronous active-low reset
//   cfg_en_i           block enable; low aborts immediately
//   cfg_div_i          bit period minus one, in clk cycles
//   cfg_bits_i         data bits minus one (out-of-range -> DATA_WIDTH)
//   cfg_parity_en_i    parity bit enable
//   cfg_parity_sel_i   00 even, 01 odd, 10 space, 11 mark
//   cfg_stop_bits_i    0 one stop bit, 1 two
//   cfg_msb_first_i    send MSB of the configured width first
//   cfg_cts_en_i       gate new frames on CTS
//   cfg_break_i        hold the line low between frames
//   cts_n_i            asynchronous clear-to-send, active low
//   tx_if (slave)      tx_data/tx_valid in, tx_ready out (combinational)
//   tx_o               serial line (registered)
//   busy_o             frame or break in progress (registered)
//   done_o             one-cycle pulse when a frame's last stop bit ends

module uart_tx_flex #(
  parameter int DATA_WIDTH = 9,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 cfg_en_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic [3:0]           cfg_bits_i,
  input  logic                 cfg_parity_en_i,
  input  logic [1:0]           cfg_parity_sel_i,
  input  logic                 cfg_stop_bits_i,
  input  logic                 cfg_msb_first_i,
  input  logic                 cfg_cts_en_i,
  input  logic                 cfg_break_i,
  input  logic                 cts_n_i,
  uart_tx_flex_if.slave        tx_if,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BREAK,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } state_e;

  localparam logic [4:0] MAX_BITS_M1 = 5'(DATA_WIDTH - 1);
  localparam logic [4:0] FULL_N      = 5'(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_q, par_d;
  logic                  tx_d, busy_d, done_d;
  logic                  cts_meta_q, cts_s_q;

  logic [4:0]            n_bits;
  logic [DATA_WIDTH-1:0] data_masked, data_rev, data_load;
  logic                  bit_end, handshake, parity_bit;

  // Out-of-range width settings fall back to the full data width.
  always_comb begin
    if (cfg_bits_i < 4'd4 || {1'b0, cfg_bits_i} > MAX_BITS_M1) begin
      n_bits = FULL_N;
    end else begin
      n_bits = {1'b0, cfg_bits_i} + 5'd1;
    end
  end

  // Mask to N bits; for MSB-first, reverse within N so the shifter always
  // sends bit 0 next.
  always_comb begin
    data_masked = '0;
    data_rev    = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < int'(n_bits)) data_masked[i] = tx_if.tx_data[i];
    end
    for (int i = 0; i < DATA_WIDTH; i++) begin
      for (int j = 0; j < DATA_WIDTH; j++) begin
        if (i < int'(n_bits) && j == int'(n_bits) - 1 - i) data_rev[i] = data_masked[j];
      end
    end
    data_load = cfg_msb_first_i ? data_rev : data_masked;
  end

  assign tx_if.tx_ready = cfg_en_i & (state_q == ST_IDLE) & ~cfg_break_i &
                          ~(cfg_cts_en_i & cts_s_q);
  assign handshake = tx_if.tx_valid & tx_if.tx_ready;
  assign bit_end   = (cnt_q == cfg_div_i);

  always_comb begin
    case (cfg_parity_sel_i)
      2'b00:   parity_bit = par_q;
      2'b01:   parity_bit = ~par_q;
      2'b10:   parity_bit = 1'b0;
      default: parity_bit = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    done_d    = 1'b0;

    // Every transition out of a timed state happens on bit_end, so clearing
    // here also restarts the counter on state entry.
    if (state_q == ST_IDLE || state_q == ST_BREAK || bit_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_break_i) begin
          state_d = ST_BREAK;
        end else if (handshake) begin
          state_d   = ST_START;
          shreg_d   = data_load;
          par_d     = ^data_masked;
          bit_cnt_d = '0;
        end
      end
      ST_BREAK: begin
        if (!cfg_break_i) state_d = ST_IDLE;
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == n_bits - 5'd1) begin
            state_d = cfg_parity_en_i ? ST_PARITY : ST_STOP1;
          end else begin
            shreg_d   = {1'b0, shreg_q[DATA_WIDTH-1:1]};
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP1;
      end
      ST_STOP1: begin
        if (bit_end) begin
          if (cfg_stop_bits_i) begin
            state_d = ST_STOP2;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_STOP2: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Disable wins over everything and drops the frame silently.
    if (!cfg_en_i) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      bit_cnt_d = '0;
      shreg_d   = '0;
      par_d     = 1'b0;
      done_d    = 1'b0;
    end

    // Line level is decoded from the next state so tx_o is a plain flop.
    case (state_d)
      ST_BREAK, ST_START: tx_d = 1'b0;
      ST_DATA:            tx_d = shreg_d[0];
      ST_PARITY:          tx_d = parity_bit;
      default:            tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cts_meta_q <= 1'b1;
      cts_s_q    <= 1'b1;
    end else begin
      cts_meta_q <= cts_n_i;
      cts_s_q    <= cts_meta_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      tx_o      <= 1'b1;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      tx_o      <= tx_d;
      busy_o    <= busy_d;
      done_o    <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_flex.sv
// tb/tb_uart_tx_flex.sv - randomized self-checking bench for uart_tx_flex

module tb_uart_tx_flex;
  localparam int DW = 9;
  localparam int VW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_en;
  logic [VW-1:0] cfg_div;
  logic [3:0]    cfg_bits;
  logic          cfg_parity_en;
  logic [1:0]    cfg_parity_sel;
  logic          cfg_stop_bits;
  logic          cfg_msb_first;
  logic          cfg_cts_en;
  logic          cfg_break;
  logic          cts_n;
  logic          tx, busy, done;

  int total = 0;
  int bad   = 0;
  bit exp_bits[$];

  uart_tx_flex_if #(.DATA_WIDTH(DW)) tx_if ();

  uart_tx_flex #(.DATA_WIDTH(DW), .DIV_WIDTH(VW)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .cfg_en_i        (cfg_en),
    .cfg_div_i       (cfg_div),
    .cfg_bits_i      (cfg_bits),
    .cfg_parity_en_i (cfg_parity_en),
    .cfg_parity_sel_i(cfg_parity_sel),
    .cfg_stop_bits_i (cfg_stop_bits),
    .cfg_msb_first_i (cfg_msb_first),
    .cfg_cts_en_i    (cfg_cts_en),
    .cfg_break_i     (cfg_break),
    .cts_n_i         (cts_n),
    .tx_if           (tx_if),
    .tx_o            (tx),
    .busy_o          (busy),
    .done_o          (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: effective width from the configured field.
  function automatic int n_of(input logic [3:0] b);
    if (b < 4 || int'(b) > DW - 1) return DW;
    return int'(b) + 1;
  endfunction

  // Reference: list of line levels, one entry per bit period.
  function automatic void build_frame(input logic [15:0] d);
    int n;
    int ones;
    int idx;
    n    = n_of(cfg_bits);
    ones = 0;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int k = 0; k < n; k++) begin
      idx = cfg_msb_first ? (n - 1 - k) : k;
      exp_bits.push_back(d[idx]);
      ones += int'(d[idx]);
    end
    if (cfg_parity_en) begin
      case (cfg_parity_sel)
        2'b00:   exp_bits.push_back((ones % 2) == 1);
        2'b01:   exp_bits.push_back((ones % 2) == 0);
        2'b10:   exp_bits.push_back(1'b0);
        default: exp_bits.push_back(1'b1);
      endcase
    end
    exp_bits.push_back(1'b1);
    if (cfg_stop_bits) exp_bits.push_back(1'b1);
  endfunction

  // Called right after the handshake edge; returns in the IDLE cycle after
  // the frame ends. brk_at / cts_at raise cfg_break / cts_n at that cycle.
  task automatic check_frame(input logic [15:0] d, input int brk_at, input int cts_at,
                             input string tag);
    int per;
    int cyc;
    per = int'(cfg_div) + 1;
    build_frame(d);
    cyc = 0;
    for (int b = 0; b < exp_bits.size(); b++) begin
      for (int c = 0; c < per; c++) begin
        check_eq({tag, "_tx"}, 32'(tx), 32'(exp_bits[b]));
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_ready"}, 32'(tx_if.tx_ready), 32'd0);
        if (cyc == brk_at) cfg_break = 1'b1;
        if (cyc == cts_at) cts_n = 1'b1;
        cyc++;
        step();
      end
    end
    check_eq({tag, "_end_tx"}, 32'(tx), 32'd1);
    check_eq({tag, "_end_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_end_done"}, 32'(done), 32'd1);
  endtask

  // Presents a word and returns just after the edge that accepted it.
  task automatic send(input logic [15:0] d, input string tag);
    bit ok;
    tx_if.tx_data  = d[DW-1:0];
    tx_if.tx_valid = 1'b1;
    #1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx_if.tx_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) check_eq({tag, "_ready_timeout"}, 32'(tx_if.tx_ready), 32'd1);
    step();
    tx_if.tx_valid = 1'b0;
  endtask

  task automatic set_cfg(input int div, input int bits, input bit pen, input int psel,
                         input bit stop2, input bit msb);
    cfg_div        = VW'(div);
    cfg_bits       = 4'(bits);
    cfg_parity_en  = pen;
    cfg_parity_sel = 2'(psel);
    cfg_stop_bits  = stop2;
    cfg_msb_first  = msb;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d1, d2;

    rst_n = 1'b0; cfg_en = 1'b0; cfg_cts_en = 1'b0; cfg_break = 1'b0; cts_n = 1'b1;
    set_cfg(3, 7, 0, 0, 0, 0);
    tx_if.tx_data = '0; tx_if.tx_valid = 1'b0;
    step(); step();
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_ready", 32'(tx_if.tx_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    step();
    cfg_en = 1'b1; #1;
    check_eq("en_ready", 32'(tx_if.tx_ready), 32'd1);

    // 0xA5, 8N1, 4 cycles per bit
    set_cfg(3, 7, 0, 0, 0, 0);
    send(16'h00A5, "a5"); check_frame(16'h00A5, -1, -1, "a5");

    // 0x1FF, 9 bits, odd parity, 2 stops, MSB first, 1 cycle per bit
    set_cfg(0, 8, 1, 1, 1, 1);
    send(16'h01FF, "x1ff"); check_frame(16'h01FF, -1, -1, "x1ff");

    // back-to-back 0x55 then 0x0F with N=5
    set_cfg(1, 4, 0, 0, 0, 0);
    send(16'h0055, "b2b1");
    tx_if.tx_data = 9'h00F; tx_if.tx_valid = 1'b1;
    check_frame(16'h0055, -1, -1, "b2b1");
    check_eq("b2b_ready", 32'(tx_if.tx_ready), 32'd1);
    step();
    tx_if.tx_valid = 1'b0;
    check_frame(16'h000F, -1, -1, "b2b2");

    // CTS gating: blocked while high, ready 2 edges after it drops
    set_cfg(1, 7, 0, 0, 0, 0);
    cfg_cts_en = 1'b1; cts_n = 1'b1;
    step(); step();
    tx_if.tx_data = 9'h03C; tx_if.tx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; check_eq("cts_block", 32'(tx_if.tx_ready), 32'd0);
      step();
    end
    cts_n = 1'b0;
    step(); check_eq("cts_sync1", 32'(tx_if.tx_ready), 32'd0);
    step(); check_eq("cts_sync2", 32'(tx_if.tx_ready), 32'd1);
    step();
    tx_if.tx_valid = 1'b0;
    check_frame(16'h003C, -1, 5, "cts");
    step();
    check_eq("cts_block_after", 32'(tx_if.tx_ready), 32'd0);
    cfg_cts_en = 1'b0; cts_n = 1'b0;
    step(); step();

    // break requested at the third data bit
    set_cfg(1, 7, 1, 0, 0, 0);
    send(16'h00C3, "brk");
    check_frame(16'h00C3, 3 * 2, -1, "brk");
    check_eq("brk_ready", 32'(tx_if.tx_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("brk_tx", 32'(tx), 32'd0);
      check_eq("brk_busy", 32'(busy), 32'd1);
      check_eq("brk_done", 32'(done), 32'd0);
    end
    cfg_break = 1'b0;
    step();
    check_eq("brk_end_tx", 32'(tx), 32'd1);
    check_eq("brk_end_busy", 32'(busy), 32'd0);
    check_eq("brk_end_done", 32'(done), 32'd0);

    // disable during DATA
    set_cfg(1, 7, 0, 0, 0, 0);
    send(16'h0000, "dis");
    for (int i = 0; i < 4; i++) step();
    check_eq("dis_mid_busy", 32'(busy), 32'd1);
    check_eq("dis_mid_tx", 32'(tx), 32'd0);
    cfg_en = 1'b0; #1;
    check_eq("dis_ready", 32'(tx_if.tx_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("dis_tx", 32'(tx), 32'd1);
      check_eq("dis_busy", 32'(busy), 32'd0);
      check_eq("dis_done", 32'(done), 32'd0);
    end
    cfg_en = 1'b1;
    send(16'h0096, "reen"); check_frame(16'h0096, -1, -1, "reen");

    // async reset mid-frame
    set_cfg(2, 7, 1, 1, 1, 0);
    send(16'h0000, "arst");
    for (int i = 0; i < 5; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_tx", 32'(tx), 32'd1);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    step();
    send(16'h005A, "post_rst"); check_frame(16'h005A, -1, -1, "post_rst");

    // randomized frames, including out-of-range widths and back-to-back pairs
    for (int f = 0; f < 40; f++) begin
      set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      d1 = 16'($urandom);
      d2 = 16'($urandom);
      send(d1, "rnd1");
      if ($urandom_range(0, 1) == 1) begin
        tx_if.tx_data = d2[DW-1:0]; tx_if.tx_valid = 1'b1;
        check_frame(d1, -1, -1, "rnd1");
        check_eq("rnd_b2b_ready", 32'(tx_if.tx_ready), 32'd1);
        step();
        tx_if.tx_valid = 1'b0;
        check_frame(d2, -1, -1, "rnd2");
      end else begin
        check_frame(d1, -1, -1, "rnd1");
        for (int i = 0; i < int'($urandom_range(0, 3)); i++) step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
